// File: rtl/find_max_pkg.sv
// find_max_pkg
// Shared definitions for the find_MAX upstream sequencer: default
// parameter values, the sequencer state encoding and the beat layout.
// No ports (package).
package find_max_pkg;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_FIFO_DEPTH = 8;
    localparam int DEF_GAP_CYCLES = 1;
    localparam int DEF_RESULT_LAT = 2;

    // Sequencer states; encoding is fixed so dbg_state is stable across builds.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_GAP     = 3'd2,
        ST_BEAT    = 3'd3,
        ST_WAIT    = 3'd4,
        ST_DRAIN   = 3'd5,
        ST_CAPTURE = 3'd6
    } state_t;

    // Beat layout at the default data width, MSB first: {a, b, c, instr, sel}.
    typedef struct packed {
        logic [DEF_DATA_W-1:0] a;
        logic [DEF_DATA_W-1:0] b;
        logic [DEF_DATA_W-1:0] c;
        logic [DEF_DATA_W-1:0] instr;
        logic [2:0]            sel;
    } beat_t;

    // Packed beat width for an arbitrary data width (same field order as beat_t).
    function automatic int beat_width(input int data_w);
        return 4 * data_w + 3;
    endfunction

endpackage

// File: rtl/find_max_beat_fifo.sv
// find_max_beat_fifo
// Synchronous FIFO holding buffered operand beats.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset (empties the FIFO)
//   i_push, i_data push request and data; ignored while full
//   i_pop          pop request; ignored while empty
//   o_head         entry at the read pointer (valid when !o_empty)
//   o_full, o_empty occupancy flags
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// DEPTH must be a power of two, >= 2.
module find_max_beat_fifo
    import find_max_pkg::*;
#(
    parameter int WIDTH = beat_width(DEF_DATA_W),
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    // Full blocks a push even when a pop happens in the same cycle.
    assign w_do_push = i_push && !w_full;
    assign w_do_pop  = i_pop && !w_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage needs no reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule

// File: rtl/find_max_sequencer.sv
// find_max_sequencer
// Replays an operation (header with beat count + buffered beats) into
// find_MAX as a start/count pulse followed by spaced valid beats, then
// after a fixed drain delay captures second_maximum and pulses res_valid.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_count  operation header handshake (0..7 beats)
//   beat_in_valid/beat_in_ready    beat handshake; beat_a/b/c, beat_instr, beat_sel
//   start, count                   operation start pulse and beat count to find_MAX
//   valid, data_A/B/C, instruction, select  beat stream to find_MAX (0 when !valid)
//   second_maximum                 result from find_MAX
//   res_valid, res_data            one-cycle result pulse, held result value
//   op_done_cnt                    completed operation counter (wraps)
//   busy                           high whenever not IDLE
//   dbg_state                      current sequencer state
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; ready never depends combinationally on the matching valid.
module find_max_sequencer
    import find_max_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int RESULT_LAT = DEF_RESULT_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_count,
    input  logic              beat_in_valid,
    output logic              beat_in_ready,
    input  logic [DATA_W-1:0] beat_a,
    input  logic [DATA_W-1:0] beat_b,
    input  logic [DATA_W-1:0] beat_c,
    input  logic [DATA_W-1:0] beat_instr,
    input  logic [2:0]        beat_sel,
    output logic              start,
    output logic [2:0]        count,
    output logic              valid,
    output logic [DATA_W-1:0] data_A,
    output logic [DATA_W-1:0] data_B,
    output logic [DATA_W-1:0] data_C,
    output logic [DATA_W-1:0] instruction,
    output logic [2:0]        select,
    input  logic [DATA_W-1:0] second_maximum,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic [7:0]        op_done_cnt,
    output logic              busy,
    output state_t            dbg_state
);

    localparam int BEAT_W = beat_width(DATA_W);
    // Timers count down to zero, so they are loaded with (length - 1).
    localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] DRAIN_LAST = 16'(RESULT_LAT - 1);

    state_t            r_state;
    logic [2:0]        r_n;
    logic [2:0]        r_beat_cnt;
    logic [15:0]       r_timer;
    logic              r_start;
    logic [2:0]        r_count;
    logic              r_valid;
    logic [BEAT_W-1:0] r_beat;
    logic              r_res_valid;
    logic [DATA_W-1:0] r_res_data;
    logic [7:0]        r_done_cnt;

    logic [BEAT_W-1:0] w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;

    // The head is consumed on the BEAT cycle; it was already copied into the
    // registered beat outputs on the edge that entered BEAT.
    assign w_pop = (r_state == ST_BEAT);

    find_max_beat_fifo #(
        .WIDTH (BEAT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (beat_in_valid),
        .i_data  ({beat_a, beat_b, beat_c, beat_instr, beat_sel}),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_n         <= '0;
            r_beat_cnt  <= '0;
            r_timer     <= '0;
            r_start     <= 1'b0;
            r_count     <= '0;
            r_valid     <= 1'b0;
            r_beat      <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_done_cnt  <= '0;
        end else begin
            // Pulse outputs default to idle; states below raise them for one cycle.
            r_start     <= 1'b0;
            r_count     <= '0;
            r_valid     <= 1'b0;
            r_beat      <= '0;
            r_res_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_n        <= cmd_count;
                        r_beat_cnt <= '0;
                        r_start    <= 1'b1;
                        r_count    <= cmd_count;
                        r_state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (r_n == 3'd0) begin
                        r_timer <= DRAIN_LAST;
                        r_state <= ST_DRAIN;
                    end else begin
                        r_timer <= GAP_LAST;
                        r_state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (r_timer != 16'd0) begin
                        r_timer <= r_timer - 16'd1;
                    end else if (!w_empty) begin
                        r_valid <= 1'b1;
                        r_beat  <= w_head;
                        r_state <= ST_BEAT;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!w_empty) begin
                        r_valid <= 1'b1;
                        r_beat  <= w_head;
                        r_state <= ST_BEAT;
                    end
                end
                ST_BEAT: begin
                    r_beat_cnt <= r_beat_cnt + 3'd1;
                    if (r_beat_cnt + 3'd1 == r_n) begin
                        r_timer <= DRAIN_LAST;
                        r_state <= ST_DRAIN;
                    end else begin
                        r_timer <= GAP_LAST;
                        r_state <= ST_GAP;
                    end
                end
                ST_DRAIN: begin
                    if (r_timer != 16'd0) begin
                        r_timer <= r_timer - 16'd1;
                    end else begin
                        // Last drain edge: find_MAX has settled, take its result.
                        r_res_data  <= second_maximum;
                        r_res_valid <= 1'b1;
                        r_done_cnt  <= r_done_cnt + 8'd1;
                        r_state     <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready     = (r_state == ST_IDLE);
    assign beat_in_ready = !w_full;
    assign busy          = (r_state != ST_IDLE);
    assign dbg_state     = r_state;

    assign start         = r_start;
    assign count         = r_count;
    assign valid         = r_valid;
    assign {data_A, data_B, data_C, instruction, select} = r_beat;
    assign res_valid     = r_res_valid;
    assign res_data      = r_res_data;
    assign op_done_cnt   = r_done_cnt;

endmodule

// File: tb/tb_find_max_sequencer.sv
module tb_find_max_sequencer;
    import find_max_pkg::*;

    localparam int DW  = 8;
    localparam int GAP = 1;
    localparam int RL  = 2;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // cyc holds the number of the most recent rising edge. A header accepted
    // on edge e gives "cycle e+k" (k counted from the cycle after e, k=1 first)
    // the bench value acc+k-1.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_count = '0;
    logic          beat_in_valid = 1'b0;
    logic          beat_in_ready;
    logic [DW-1:0] beat_a = '0, beat_b = '0, beat_c = '0, beat_instr = '0;
    logic [2:0]    beat_sel = '0;
    logic          start;
    logic [2:0]    count;
    logic          valid;
    logic [DW-1:0] data_A, data_B, data_C, instruction;
    logic [2:0]    select;
    logic [DW-1:0] second_maximum = '0;
    logic          res_valid;
    logic [DW-1:0] res_data;
    logic [7:0]    op_done_cnt;
    logic          busy;
    state_t        dbg_state;

    find_max_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_count      (cmd_count),
        .beat_in_valid  (beat_in_valid),
        .beat_in_ready  (beat_in_ready),
        .beat_a         (beat_a),
        .beat_b         (beat_b),
        .beat_c         (beat_c),
        .beat_instr     (beat_instr),
        .beat_sel       (beat_sel),
        .start          (start),
        .count          (count),
        .valid          (valid),
        .data_A         (data_A),
        .data_B         (data_B),
        .data_C         (data_C),
        .instruction    (instruction),
        .select         (select),
        .second_maximum (second_maximum),
        .res_valid      (res_valid),
        .res_data       (res_data),
        .op_done_cnt    (op_done_cnt),
        .busy           (busy),
        .dbg_state      (dbg_state)
    );

    // ---------------- scoreboard / model state ----------------
    logic [34:0] exp_q[$];     // model of beats accepted and not yet replayed
    logic [7:0]  exp_done = '0; // model of completed operations
    int total = 0;
    int bad   = 0;

    // Observations collected on the falling edge.
    logic [34:0] obs_q[$];
    int          obs_t[$];
    int          res_t[$];
    logic [7:0]  res_d[$];
    int          st_t[$];
    logic [2:0]  st_n[$];
    int          idle_viol   = 0;
    int          cnt_viol    = 0;
    int          wait_cycles = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (valid) begin
                obs_q.push_back({data_A, data_B, data_C, instruction, select});
                obs_t.push_back(cyc);
            end else if ({data_A, data_B, data_C, instruction, select} != 35'd0) begin
                idle_viol <= idle_viol + 1;
            end
            if (start) begin
                st_t.push_back(cyc);
                st_n.push_back(count);
            end else if (count != 3'd0) begin
                cnt_viol <= cnt_viol + 1;
            end
            if (res_valid) begin
                res_t.push_back(cyc);
                res_d.push_back(res_data);
            end
            if (dbg_state == ST_WAIT) wait_cycles <= wait_cycles + 1;
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [34:0] rand_beat();
        return {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 3'($urandom)};
    endfunction

    task automatic clear_mon();
        obs_q.delete(); obs_t.delete();
        res_t.delete(); res_d.delete();
        st_t.delete();  st_n.delete();
    endtask

    task automatic push_beat(input logic [34:0] b);
        int k;
        k = 0;
        {beat_a, beat_b, beat_c, beat_instr, beat_sel} = b;
        beat_in_valid = 1'b1;
        while (!beat_in_ready && k < 100) begin
            @(posedge clk); #1; k++;
        end
        total++;
        if (!beat_in_ready) begin
            bad++;
            $display("FAIL push_timeout ready=%0b required=1", beat_in_ready);
        end else begin
            @(posedge clk); #1;
            exp_q.push_back(b);
        end
        beat_in_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [2:0] n, output int acc);
        int k;
        k = 0;
        cmd_count = n;
        cmd_valid = 1'b1;
        while (!cmd_ready && k < 200) begin
            @(posedge clk); #1; k++;
        end
        total++;
        if (!cmd_ready) begin
            bad++;
            $display("FAIL cmd_timeout ready=%0b required=1", cmd_ready);
        end
        @(posedge clk); #1;
        acc = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int k;
        k = 0;
        while ((res_t.size() == 0 || busy) && k < budget) begin
            @(posedge clk); #1; k++;
        end
        ok = (k < budget);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int acc;
        // Values straight out of the power-on reset.
        total++;
        if ({start, valid, res_valid, busy, cmd_ready, beat_in_ready, op_done_cnt} !== {4'b0000, 2'b11, 8'd0}) begin
            bad++;
            $display("FAIL reset_initial got=%b required=%b",
                     {start, valid, res_valid, busy, cmd_ready, beat_in_ready, op_done_cnt}, {4'b0000, 2'b11, 8'd0});
        end
        // Reset asserted mid-cycle while an operation is in its START cycle.
        push_beat(rand_beat());
        send_cmd(3'd1, acc);
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if ({start, valid, res_valid, busy, cmd_ready, beat_in_ready, op_done_cnt, count, res_data} !==
            {4'b0000, 2'b11, 8'd0, 3'd0, 8'd0}) begin
            bad++;
            $display("FAIL reset_midop got=%b required=%b",
                     {start, valid, res_valid, busy, cmd_ready, beat_in_ready, op_done_cnt, count, res_data},
                     {4'b0000, 2'b11, 8'd0, 3'd0, 8'd0});
        end
        exp_q.delete();
        exp_done = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single_op();
        int acc;
        logic [34:0] b;
        b = {8'h10, 8'h30, 8'h20, 8'h01, 3'b010};
        push_beat(b);
        second_maximum = 8'h20;
        send_cmd(3'd1, acc);
        // e+1: start
        total++;
        if (start !== 1'b1 || count !== 3'd1) begin
            bad++;
            $display("FAIL single_start start=%0b count=%0d required 1/1", start, count);
        end
        @(posedge clk); #1;   // e+2: gap
        total++;
        if (start !== 1'b0 || valid !== 1'b0 || count !== 3'd0) begin
            bad++;
            $display("FAIL single_gap start=%0b valid=%0b count=%0d required 0/0/0", start, valid, count);
        end
        @(posedge clk); #1;   // e+3: beat
        total++;
        if (valid !== 1'b1 || {data_A, data_B, data_C, instruction, select} !== b) begin
            bad++;
            $display("FAIL single_beat valid=%0b data=%h required 1/%h",
                     valid, {data_A, data_B, data_C, instruction, select}, b);
        end
        @(posedge clk); #1;   // e+4
        @(posedge clk); #1;   // e+5
        total++;
        if (valid !== 1'b0 || res_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_drain valid=%0b res_valid=%0b required 0/0", valid, res_valid);
        end
        @(posedge clk); #1;   // e+6: result
        exp_done = exp_done + 8'd1;
        void'(exp_q.pop_front());
        total++;
        if (res_valid !== 1'b1 || res_data !== 8'h20 || op_done_cnt !== exp_done) begin
            bad++;
            $display("FAIL single_result res_valid=%0b res_data=%h done=%0d required 1/20/%0d",
                     res_valid, res_data, op_done_cnt, exp_done);
        end
        second_maximum = 8'h77;
        repeat (3) begin @(posedge clk); #1; end
        total++;
        if (res_valid !== 1'b0 || res_data !== 8'h20) begin
            bad++;
            $display("FAIL single_hold res_valid=%0b res_data=%h required 0/20", res_valid, res_data);
        end
    endtask

    task automatic test_starved();
        int acc, w0;
        bit ok;
        logic [34:0] e;
        clear_mon();
        w0 = wait_cycles;
        second_maximum = 8'($urandom);
        send_cmd(3'd3, acc);
        for (int i = 0; i < 3; i++) begin
            repeat (5) @(posedge clk);
            #1;
            push_beat(rand_beat());
        end
        wait_done(100, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL starved_timeout done=0 required=1"); end
        total++;
        if (obs_q.size() != 3 || res_t.size() != 1) begin
            bad++;
            $display("FAIL starved_counts valids=%0d results=%0d required 3/1", obs_q.size(), res_t.size());
        end
        total++;
        if (wait_cycles == w0) begin
            bad++;
            $display("FAIL starved_wait wait_cycles=%0d required >%0d", wait_cycles, w0);
        end
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            if (i < obs_q.size()) begin
                total++;
                if (obs_q[i] !== e) begin
                    bad++;
                    $display("FAIL starved_beat%0d got=%h required=%h", i, obs_q[i], e);
                end
                if (i > 0) begin
                    total++;
                    if (obs_t[i] - obs_t[i-1] < GAP + 1) begin
                        bad++;
                        $display("FAIL starved_spacing%0d got=%0d required>=%0d", i, obs_t[i] - obs_t[i-1], GAP + 1);
                    end
                end
            end
        end
        exp_done = exp_done + 8'd1;
        if (res_d.size() > 0) begin
            total++;
            if (res_d[0] !== second_maximum || op_done_cnt !== exp_done) begin
                bad++;
                $display("FAIL starved_result data=%h done=%0d required %h/%0d",
                         res_d[0], op_done_cnt, second_maximum, exp_done);
            end
        end
    endtask

    task automatic test_full();
        int acc;
        bit ok;
        logic [34:0] e;
        for (int i = 0; i < 8; i++) push_beat(rand_beat());
        total++;
        if (beat_in_ready !== 1'b0) begin
            bad++;
            $display("FAIL full_ready got=%0b required=0", beat_in_ready);
        end
        // Ninth beat offered for a few cycles must not be taken.
        {beat_a, beat_b, beat_c, beat_instr, beat_sel} = rand_beat();
        beat_in_valid = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            total++;
            if (beat_in_ready !== 1'b0) begin
                bad++;
                $display("FAIL full_ninth ready=%0b required=0", beat_in_ready);
            end
        end
        beat_in_valid = 1'b0;
        clear_mon();
        send_cmd(3'd7, acc);
        wait_done(200, ok);
        total++;
        if (!ok || obs_q.size() != 7) begin
            bad++;
            $display("FAIL full_drain valids=%0d required=7", obs_q.size());
        end
        for (int i = 0; i < 7; i++) begin
            e = exp_q.pop_front();
            if (i < obs_q.size()) begin
                total++;
                if (obs_q[i] !== e) begin
                    bad++;
                    $display("FAIL full_beat%0d got=%h required=%h", i, obs_q[i], e);
                end
            end
        end
        exp_done = exp_done + 8'd1;
        total++;
        if (beat_in_ready !== 1'b1) begin
            bad++;
            $display("FAIL full_after ready=%0b required=1", beat_in_ready);
        end
        // The eighth beat is still waiting at the head.
        clear_mon();
        send_cmd(3'd1, acc);
        wait_done(50, ok);
        e = exp_q.pop_front();
        exp_done = exp_done + 8'd1;
        total++;
        if (!ok || obs_q.size() != 1 || obs_q[0] !== e) begin
            bad++;
            $display("FAIL full_eighth valids=%0d got=%h required=%h", obs_q.size(),
                     (obs_q.size() > 0) ? obs_q[0] : 35'd0, e);
        end
    endtask

    task automatic test_zero_count();
        int acc;
        bit ok;
        clear_mon();
        second_maximum = 8'($urandom);
        send_cmd(3'd0, acc);
        wait_done(30, ok);
        exp_done = exp_done + 8'd1;
        total++;
        if (!ok || st_t.size() != 1 || st_t[0] != acc || st_n[0] !== 3'd0 || obs_q.size() != 0) begin
            bad++;
            $display("FAIL zero_start starts=%0d valids=%0d required 1/0", st_t.size(), obs_q.size());
        end
        total++;
        if (res_t.size() != 1 || res_t[0] != acc + 3 || res_d[0] !== second_maximum) begin
            bad++;
            $display("FAIL zero_result at=%0d required=%0d", (res_t.size() > 0) ? res_t[0] - acc + 1 : -1, 4);
        end
        total++;
        if (op_done_cnt !== exp_done) begin
            bad++;
            $display("FAIL zero_done got=%0d required=%0d", op_done_cnt, exp_done);
        end
    endtask

    task automatic test_random();
        int acc, n, lat;
        bit ok;
        logic [34:0] e;
        for (int it = 0; it < 12; it++) begin
            n = $urandom_range(0, 7);
            for (int i = 0; i < n; i++) push_beat(rand_beat());
            second_maximum = 8'($urandom);
            clear_mon();
            send_cmd(3'(n), acc);
            wait_done(100, ok);
            exp_done = exp_done + 8'd1;
            // Preloaded beats: no stalls, so latency follows the closed form.
            lat = 1 + n * (1 + GAP) + RL + 1;
            total++;
            if (!ok || res_t.size() != 1 || res_t[0] != acc + lat - 1 || res_d[0] !== second_maximum) begin
                bad++;
                $display("FAIL rand%0d_result n=%0d results=%0d lat=%0d required lat=%0d", it, n, res_t.size(),
                         (res_t.size() > 0) ? res_t[0] - acc + 1 : -1, lat);
            end
            total++;
            if (st_t.size() != 1 || st_n[0] !== 3'(n) || obs_q.size() != n || op_done_cnt !== exp_done) begin
                bad++;
                $display("FAIL rand%0d_shape starts=%0d valids=%0d done=%0d required 1/%0d/%0d",
                         it, st_t.size(), obs_q.size(), op_done_cnt, n, exp_done);
            end
            for (int i = 0; i < n; i++) begin
                e = exp_q.pop_front();
                if (i < obs_q.size()) begin
                    total++;
                    if (obs_q[i] !== e || obs_t[i] != acc + (i + 1) * (1 + GAP)) begin
                        bad++;
                        $display("FAIL rand%0d_beat%0d got=%h@%0d required=%h@%0d", it, i,
                                 obs_q[i], obs_t[i] - acc, e, (i + 1) * (1 + GAP));
                    end
                end
            end
        end
    endtask

    task automatic test_abort();
        int acc, nv, k;
        bit ok;
        logic [34:0] b;
        for (int i = 0; i < 4; i++) push_beat(rand_beat());
        send_cmd(3'd4, acc);
        nv = 0; k = 0;
        while (nv < 2 && k < 50) begin
            @(posedge clk); #1; k++;
            if (valid) nv++;
        end
        // Now inside the second BEAT cycle.
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_done = '0;
        total++;
        if (nv != 2 || busy !== 1'b0 || valid !== 1'b0 || cmd_ready !== 1'b1 ||
            beat_in_ready !== 1'b1 || op_done_cnt !== exp_done) begin
            bad++;
            $display("FAIL abort_reset nv=%0d busy=%0b valid=%0b done=%0d required 2/0/0/%0d",
                     nv, busy, valid, op_done_cnt, exp_done);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_mon();
        repeat (10) begin @(posedge clk); #1; end
        total++;
        if (res_t.size() != 0 || obs_q.size() != 0) begin
            bad++;
            $display("FAIL abort_quiet results=%0d valids=%0d required 0/0", res_t.size(), obs_q.size());
        end
        b = rand_beat();
        push_beat(b);
        second_maximum = 8'($urandom);
        send_cmd(3'd1, acc);
        wait_done(50, ok);
        void'(exp_q.pop_front());
        exp_done = exp_done + 8'd1;
        total++;
        if (!ok || obs_q.size() != 1 || obs_q[0] !== b || res_d[0] !== second_maximum || op_done_cnt !== exp_done) begin
            bad++;
            $display("FAIL abort_next valids=%0d got=%h done=%0d required 1/%h/%0d", obs_q.size(),
                     (obs_q.size() > 0) ? obs_q[0] : 35'd0, op_done_cnt, b, exp_done);
        end
    endtask

    task automatic test_wrap();
        int acc;
        bit ok;
        bit saw_zero;
        saw_zero = 1'b0;
        for (int i = 0; i < 256; i++) begin
            clear_mon();
            send_cmd(3'd0, acc);
            wait_done(30, ok);
            exp_done = exp_done + 8'd1;
            total++;
            if (!ok || op_done_cnt !== exp_done) begin
                bad++;
                $display("FAIL wrap%0d done=%0d required=%0d", i, op_done_cnt, exp_done);
            end
            if (op_done_cnt === 8'd0) saw_zero = 1'b1;
        end
        total++;
        if (!saw_zero) begin
            bad++;
            $display("FAIL wrap_zero seen=0 required=1");
        end
    endtask

    task automatic test_idle_outputs();
        total++;
        if (idle_viol != 0 || cnt_viol != 0) begin
            bad++;
            $display("FAIL idle_outputs data_cycles=%0d count_cycles=%0d required 0/0", idle_viol, cnt_viol);
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_reset();
        test_single_op();
        test_starved();
        test_full();
        test_zero_count();
        test_random();
        test_abort();
        test_wrap();
        test_idle_outputs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
